// File: rtl/reg_file_sb.sv
// Integer register file with write-back extension, same-cycle forwarding,
// a per-register pending scoreboard and a sequential clear engine.

module reg_file_sb_cell #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr,
    input  logic            clr,
    input  logic            set,
    input  logic [XLEN-1:0] d,
    output logic [XLEN-1:0] q,
    output logic            pend
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)   q <= '0;
        else if (clr) q <= '0;
        else if (wr)  q <= d;
    end

    // A new issue outranks the retiring write to the same register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)   pend <= 1'b0;
        else if (clr) pend <= 1'b0;
        else if (set) pend <= 1'b1;
        else if (wr)  pend <= 1'b0;
    end
endmodule

module reg_file_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr_req,
    output logic            clr_busy,
    input  logic            we,
    input  logic [1:0]      wsize,
    input  logic            wunsigned,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    output logic            pend1,
    output logic            pend2
);
    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    state_t                       state, state_nxt;
    logic [AW-1:0]                idx, idx_nxt;
    logic                         idle;
    logic [XLEN-1:0]              ext;
    logic [NREGS-1:1]             wr_hit, set_hit, clr_hit;
    logic [NREGS-1:0][XLEN-1:0]   regs;
    logic [NREGS-1:0]             pend_v;
    logic                         fwd_en, fwd1, fwd2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    idx_nxt   = '0;
                end
            end
            CLEAR: begin
                if (idx == LAST) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign idle     = (state == IDLE);
    assign clr_busy = (state == CLEAR);

    always_comb begin
        case (wsize)
            2'b00:   ext = {{(XLEN-8){~wunsigned & wdata[7]}}, wdata[7:0]};
            2'b01:   ext = {{(XLEN-16){~wunsigned & wdata[15]}}, wdata[15:0]};
            default: ext = wdata;
        endcase
    end

    always_comb begin
        wr_hit  = '0;
        set_hit = '0;
        clr_hit = '0;
        for (int i = 1; i < NREGS; i++) begin
            wr_hit[i]  = idle && we && (waddr == AW'(i));
            set_hit[i] = idle && iss_valid && (iss_rd == AW'(i));
            clr_hit[i] = !idle && (idx == AW'(i));
        end
    end

    // Register 0 is hardwired; only 1..NREGS-1 hold state.
    assign regs[0]   = '0;
    assign pend_v[0] = 1'b0;

    for (genvar i = 1; i < NREGS; i++) begin : g_reg
        reg_file_sb_cell #(.XLEN(XLEN)) u_cell (
            .clk   (clk),
            .reset (reset),
            .wr    (wr_hit[i]),
            .clr   (clr_hit[i]),
            .set   (set_hit[i]),
            .d     (ext),
            .q     (regs[i]),
            .pend  (pend_v[i])
        );
    end

    // Forwarding is also gated by reset so outputs stay zero while it is held.
    assign fwd_en = (BYPASS != 0) && idle && we && reset;
    assign fwd1   = fwd_en && (waddr == rs1) && (rs1 != '0);
    assign fwd2   = fwd_en && (waddr == rs2) && (rs2 != '0);

    assign rdata1 = !reset ? '0 : (fwd1 ? ext : regs[rs1]);
    assign rdata2 = !reset ? '0 : (fwd2 ? ext : regs[rs2]);
    assign pend1  = reset && pend_v[rs1] && !fwd1;
    assign pend2  = reset && pend_v[rs2] && !fwd2;
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter XLEN, default 32, register data width in bits; SHALL be 16 or greater.
REQ-002 Parameter NREGS, default 32, register count; SHALL be a power of two, 2 or greater; AW = log2(NREGS).
REQ-003 Parameter BYPASS, default 1: 1 enables write-to-read forwarding; 0 disables it.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 clr_req  in  1  request to start a sequential clear of all registers.
REQ-007 clr_busy  out  1  high while the clear sequence runs.
REQ-008 we  in  1  write-back enable.
REQ-009 wsize  in  2  write size: 00 byte, 01 half, 10/11 word.
REQ-010 wunsigned  in  1  1 zero-extends sub-word writes; 0 sign-extends them.
REQ-011 waddr  in  AW  write-back destination register.
REQ-012 wdata  in  XLEN  write-back data; sub-word data is taken from the low bits.
REQ-013 iss_valid  in  1  issue strobe; marks iss_rd as pending.
REQ-014 iss_rd  in  AW  destination register of the issuing instruction.
REQ-015 rs1, rs2  in  AW  read addresses.
REQ-016 rdata1, rdata2  out  XLEN  combinational read data.
REQ-017 pend1, pend2  out  1  combinational pending status for rs1 and rs2.

Function
REQ-018 Register 0 SHALL always read 0 and never be pending; writes and issues targeting register 0 SHALL be ignored.
REQ-019 Extended write value ext SHALL be computed as follows: byte = wdata[7:0], half = wdata[15:0], each extended to XLEN per wunsigned; word = wdata[XLEN-1:0], with wunsigned ignored.
REQ-020 When we=1, state IDLE and waddr!=0, reg[waddr] SHALL take ext at the clock edge; all other registers SHALL hold.
REQ-021 rdataN SHALL equal reg[rsN], except under forwarding.
REQ-022 Forwarding: with BYPASS=1, IDLE, we=1, waddr==rsN and rsN!=0, rdataN SHALL equal ext in the same cycle; with BYPASS=0, the new value SHALL be visible only from the cycle after the write edge.
REQ-023 The pending vector pend_v[NREGS-1:0] SHALL update as follows:
- iss_valid=1 in IDLE SHALL set pend_v[iss_rd] at the edge.
- we=1 in IDLE SHALL clear pend_v[waddr] at the edge.
REQ-024 If iss_valid and we target the same register in the same cycle, pend_v for that register SHALL end set (the new issue wins).
REQ-025 pendN SHALL equal pend_v[rsN] AND NOT (BYPASS AND we AND waddr==rsN AND IDLE), and SHALL be 0 for rsN=0.
REQ-026 A write to a register that is not pending SHALL still be performed, with no error reported.
REQ-027 The FSM SHALL have two states, IDLE and CLEAR:
- IDLE -> CLEAR on clr_req=1; the clear index loads 0.
- In CLEAR, each cycle SHALL zero reg[idx], zero pend_v[idx] and increment idx.
- After idx = NREGS-1 is processed, the FSM SHALL return to IDLE.
- Total duration SHALL be exactly NREGS cycles.
REQ-028 clr_busy SHALL be 1 exactly in CLEAR.
REQ-029 While in CLEAR, we, iss_valid and clr_req SHALL be ignored and forwarding SHALL be disabled; reads SHALL return stored contents, partially cleared.
REQ-030 The clear index SHALL be AW bits wide; it SHALL NOT wrap within one sequence, and no second pass SHALL occur.
REQ-031 If clr_req and we arrive in the same IDLE cycle, the write SHALL be performed at that edge, and CLEAR SHALL start on the following cycle.

Reset
REQ-032 Assertion of reset (low) SHALL immediately force:
- all registers to 0;
- pend_v to 0;
- FSM to IDLE;
- clear index to 0;
- clr_busy to 0.
REQ-033 Reset asserted mid-CLEAR SHALL abort the sequence; after reset release the block SHALL be in IDLE.
REQ-034 With reset asserted, rdata1, rdata2, pend1 and pend2 SHALL be 0 for every address.
REQ-035 The first write or issue SHALL be accepted on the first rising edge after reset is released.

Verification
REQ-036 Write and extension:
- Stimulus: write 0x000000F0 to x5 with wsize=00, wunsigned=0; then 0x00008001 to x6 with wsize=01, wunsigned=1.
- Response: x5 reads 0xFFFFFFF0; x6 reads 0x00008001.
REQ-037 Forwarding:
- Stimulus: we=1, waddr=7, wdata=0x12345678, rs1=7 in the same cycle.
- Response: rdata1=0x12345678 in that cycle with BYPASS=1; the old value in that cycle with BYPASS=0.
REQ-038 Scoreboard:
- Stimulus: issue x3; then, two cycles later, a write to x3.
- Response: pend1 (rs1=3) is 1 from the edge after the issue; it is 0 during the write cycle when BYPASS=1, and from the following cycle when BYPASS=0.
REQ-039 Simultaneous events:
- Stimulus: iss_valid with iss_rd=4 and we with waddr=4 in the same cycle.
- Response: x4 is updated and pend_v[4] remains 1.
REQ-040 Clear:
- Stimulus: fill all registers with nonzero values; pulse clr_req.
- Response: clr_busy is high for exactly 32 cycles; writes issued during that time have no effect; all registers read 0 afterwards.
REQ-041 Reset mid-clear:
- Stimulus: assert reset at clear index 10.
- Response: all outputs are 0 immediately; after release, clr_busy=0 and a write to x1 succeeds.
